// File: rtl/trap_ctrl_pkg.sv
// Shared types for the trap controller: exception cause, FSM states and the
// trap-vector mode field layout.
package trap_ctrl_pkg;

    localparam int AddrWidth    = 32;
    localparam int DataWidth    = 32;
    localparam int ExpCodeWidth = 5;

    typedef logic [ExpCodeWidth-1:0] ExpCode_t;

    typedef enum logic [2:0] {
        TS_IDLE  = 3'd0,
        TS_FLUSH = 3'd1,
        TS_DRAIN = 3'd2,
        TS_CSR   = 3'd3,
        TS_REDIR = 3'd4,
        TS_HALT  = 3'd5
    } TrapState_t;

    // Low two bits of tvec select the mode; the rest is the handler base.
    typedef enum logic [1:0] {
        TVEC_DIRECT   = 2'd0,
        TVEC_VECTORED = 2'd1,
        TVEC_RSVD2    = 2'd2,
        TVEC_RSVD3    = 2'd3
    } TvecMode_t;

    function automatic TvecMode_t tvec_mode(input logic [1:0] field);
        return TvecMode_t'(field);
    endfunction

endpackage

// File: rtl/trap_ctrl_exp_manage.sv
// Handler PC from the trap-vector CSR: base in direct/reserved modes,
// base plus 4*cause in vectored mode (wraps silently at ADDR bits).
module exp_manage
    import trap_ctrl_pkg::*;
#(
    parameter int ADDR = AddrWidth,
    parameter int DATA = DataWidth
) (
    input  ExpCode_t        i_code,
    input  logic [DATA-1:0] i_tvec,
    output logic [ADDR-1:0] o_pc
);

    logic [ADDR-1:0] w_base;
    logic [ADDR-1:0] w_off;

    assign w_base = ADDR'({i_tvec[DATA-1:2], 2'b00});
    assign w_off  = ADDR'({i_code, 2'b00});

    always_comb begin
        o_pc = w_base;
        if (tvec_mode(i_tvec[1:0]) == TVEC_VECTORED) begin
            o_pc = w_base + w_off;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Trap entry / mret sequencer: flush, wait for drain, write trap CSRs,
// then redirect fetch to the handler or the saved EPC.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int ADDR     = AddrWidth,
    parameter int DATA     = DataWidth,
    parameter int DRAIN_TO = 255
) (
    input  logic            clk,
    input  logic            reset_,
    input  logic            commit_exp_,
    input  ExpCode_t        commit_exp_code,
    input  logic [ADDR-1:0] commit_pc,
    input  logic [DATA-1:0] commit_tval,
    input  logic            commit_mret_,
    input  logic            drain_done_,
    input  logic            creg_exp_mask,
    input  logic [DATA-1:0] creg_tvec,
    input  logic [ADDR-1:0] creg_epc,
    output logic            flush_,
    output logic            trap_we_,
    output logic [ADDR-1:0] trap_epc,
    output ExpCode_t        trap_cause,
    output logic [DATA-1:0] trap_tval,
    output logic            mret_,
    output logic            redirect_,
    output logic [ADDR-1:0] redirect_pc,
    output logic            busy,
    output logic            halt
);

    localparam int CntW = $clog2(DRAIN_TO + 1);

    TrapState_t      r_state;
    TrapState_t      w_next;
    logic            r_is_mret;
    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_inc;
    logic [ADDR-1:0] r_epc;
    ExpCode_t        r_cause;
    logic [DATA-1:0] r_tval;
    logic [ADDR-1:0] w_handler;
    logic            w_take_exp;
    logic            w_take_mret;

    assign w_take_exp  = (r_state == TS_IDLE) && !commit_exp_;
    assign w_take_mret = (r_state == TS_IDLE) && commit_exp_ && !commit_mret_;
    assign w_cnt_inc   = r_cnt + CntW'(1);

    exp_manage #(
        .ADDR (ADDR),
        .DATA (DATA)
    ) u_exp_manage (
        .i_code (r_cause),
        .i_tvec (creg_tvec),
        .o_pc   (w_handler)
    );

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_state <= TS_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Trap fields latch on every accepted exception, nested ones included,
    // and hold until the next one.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_is_mret <= 1'b0;
            r_cnt     <= '0;
            r_epc     <= '0;
            r_cause   <= '0;
            r_tval    <= '0;
        end else begin
            if (w_take_exp) begin
                r_epc     <= commit_pc;
                r_cause   <= commit_exp_code;
                r_tval    <= commit_tval;
                r_is_mret <= 1'b0;
            end else if (w_take_mret) begin
                r_is_mret <= 1'b1;
            end
            if (r_state == TS_FLUSH) begin
                r_cnt <= '0;
            end else if (r_state == TS_DRAIN && drain_done_) begin
                r_cnt <= w_cnt_inc;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            TS_IDLE: begin
                if (!commit_exp_) begin
                    w_next = creg_exp_mask ? TS_HALT : TS_FLUSH;
                end else if (!commit_mret_) begin
                    w_next = TS_FLUSH;
                end
            end
            TS_FLUSH: w_next = TS_DRAIN;
            TS_DRAIN: begin
                if (!drain_done_) begin
                    w_next = r_is_mret ? TS_REDIR : TS_CSR;
                end else if (w_cnt_inc == CntW'(DRAIN_TO)) begin
                    w_next = TS_HALT;
                end
            end
            TS_CSR:   w_next = TS_REDIR;
            TS_REDIR: w_next = TS_IDLE;
            TS_HALT:  w_next = TS_HALT;
            default:  w_next = TS_IDLE;
        endcase
    end

    // Strobes decode the state register only, so nothing glitches on inputs.
    always_comb begin
        flush_      = 1'b1;
        trap_we_    = 1'b1;
        mret_       = 1'b1;
        redirect_   = 1'b1;
        redirect_pc = '0;
        case (r_state)
            TS_FLUSH: flush_   = 1'b0;
            TS_CSR:   trap_we_ = 1'b0;
            TS_REDIR: begin
                redirect_   = 1'b0;
                mret_       = !r_is_mret;
                redirect_pc = r_is_mret ? creg_epc : w_handler;
            end
            default: ;
        endcase
    end

    assign busy       = (r_state != TS_IDLE);
    assign halt       = (r_state == TS_HALT);
    assign trap_epc   = r_epc;
    assign trap_cause = r_cause;
    assign trap_tval  = r_tval;

endmodule
